jump_redirect: RTL

Consumer side of the jump forwarding/stall handshake in the 5-stage MIPS pipeline. Sits in ID beside the jump-hazard detector: takes its `ForwardJ`/`stallJ` verdict, freezes PC and IF/ID while a `jr`/`jalr` source is still in flight, selects the forwarded register value, then issues a registered one-cycle PC redirect plus IF/ID flush. Also resolves `j`/`jal` targets, so all ID-stage jumps share one redirect path.

---
 rtl/jump_redirect_if.sv | 35 +++
 rtl/jump_redirect.sv | 130 +++++++++++++
 2 files changed

// File: rtl/jump_redirect_if.sv
// ID-stage jump handshake bundle: hazard verdict and jump operands in, PC / IF-ID control out.
// master = ID / hazard-detector side, slave = jump_redirect.
interface jump_redirect_if;
    logic        ID_valid;
    logic        ID_is_j;
    logic        ID_is_jr;
    logic [25:0] ID_target;
    logic [31:0] ID_PC4;
    logic [31:0] RegJumpData;
    logic [1:0]  ForwardJ;
    logic        stallJ;
    logic [31:0] EXMEM_ALUResult;
    logic [31:0] MEMWB_WriteData;
    logic        ext_stall;
    logic        PC_redirect;
    logic [31:0] PC_target;
    logic        PC_hold;
    logic        IFID_hold;
    logic        IFID_flush;
    logic        jr_err;
    logic [15:0] jump_cnt;
    logic [15:0] jwait_cnt;

    modport master (
        output ID_valid, ID_is_j, ID_is_jr, ID_target, ID_PC4, RegJumpData, ForwardJ, stallJ,
               EXMEM_ALUResult, MEMWB_WriteData, ext_stall,
        input  PC_redirect, PC_target, PC_hold, IFID_hold, IFID_flush, jr_err, jump_cnt, jwait_cnt
    );

    modport slave (
        input  ID_valid, ID_is_j, ID_is_jr, ID_target, ID_PC4, RegJumpData, ForwardJ, stallJ,
               EXMEM_ALUResult, MEMWB_WriteData, ext_stall,
        output PC_redirect, PC_target, PC_hold, IFID_hold, IFID_flush, jr_err, jump_cnt, jwait_cnt
    );
endinterface

// File: rtl/jump_redirect.sv
// ID-stage jump redirect: freezes PC/IF-ID while a jr/jalr source is in flight, then issues a
// one-cycle registered PC redirect plus IF/ID flush. Define JUMP_PERF_EN to build jump_cnt/jwait_cnt.
//
// state | meaning
// IDLE  | no jump pending; accepts j/jal and jr/jalr from ID
// WAIT  | jr/jalr source still in flight; PC and IF/ID frozen while stallJ
// REDIR | PC_redirect and IFID_flush asserted; ID contents ignored (being flushed)
module jump_redirect #(
    parameter int WAIT_MAX = 2
) (
    input logic            clk,
    input logic            rst_n,
    jump_redirect_if.slave jif
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, REDIR = 2'd2} state_t;

    state_t      state, stateNext;
    logic [2:0]  waitCnt, waitCntNext;
    logic [31:0] target, targetNext;
    logic        redirect;
    logic        jrErr, jrErrNext;
    logic        stallHold;
    logic        jumpReq, jrReq;
    logic [31:0] fwdData;
    logic [31:0] jTarget;
    logic        unusedPc4Low;

    assign jumpReq      = jif.ID_valid & (jif.ID_is_j | jif.ID_is_jr);
    assign jrReq        = jif.ID_valid & jif.ID_is_jr;
    assign jTarget      = {jif.ID_PC4[31:28], jif.ID_target, 2'b00};
    assign unusedPc4Low = ^jif.ID_PC4[27:0];

    always_comb begin
        fwdData = jif.RegJumpData;
        case (jif.ForwardJ)
            2'b01:   fwdData = jif.EXMEM_ALUResult;
            2'b10:   fwdData = jif.MEMWB_WriteData;
            default: fwdData = jif.RegJumpData;
        endcase
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        targetNext  = target;
        jrErrNext   = jrErr;
        stallHold   = 1'b0;
        case (state)
            IDLE: begin
                if (!jif.ext_stall && jumpReq) begin
                    if (jrReq) begin
                        if (jif.stallJ) begin
                            // Freeze already in the request cycle so the jr stays in IF/ID.
                            stallHold   = rst_n;
                            waitCntNext = 3'd1;
                            stateNext   = WAIT;
                        end else begin
                            targetNext = fwdData;
                            stateNext  = REDIR;
                        end
                    end else begin
                        targetNext = jTarget;
                        stateNext  = REDIR;
                    end
                end
            end
            WAIT: begin
                stallHold = jif.stallJ;
                if (!jif.ext_stall) begin
                    if (!jif.stallJ) begin
                        targetNext = fwdData;
                        stateNext  = REDIR;
                    end else begin
                        if (waitCnt != 3'd7) waitCntNext = waitCnt + 3'd1;
                        if (int'({29'd0, waitCntNext}) > WAIT_MAX) jrErrNext = 1'b1;
                    end
                end
            end
            REDIR: begin
                if (!jif.ext_stall) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            waitCnt  <= 3'd0;
            target   <= 32'd0;
            redirect <= 1'b0;
            jrErr    <= 1'b0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitCntNext;
            target   <= targetNext;
            redirect <= (stateNext == REDIR);
            jrErr    <= jrErrNext;
        end
    end

    assign jif.PC_redirect = redirect;
    assign jif.IFID_flush  = redirect;
    assign jif.PC_target   = target;
    assign jif.PC_hold     = stallHold;
    assign jif.IFID_hold   = stallHold;
    assign jif.jr_err      = jrErr;

`ifdef JUMP_PERF_EN
    logic [15:0] jumpCnt, jwaitCnt;

    // Stall cycles include the request cycle that enters WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jumpCnt  <= 16'd0;
            jwaitCnt <= 16'd0;
        end else begin
            if ((stateNext == REDIR) && (state != REDIR)) jumpCnt <= jumpCnt + 16'd1;
            if (stallHold) jwaitCnt <= jwaitCnt + 16'd1;
        end
    end

    assign jif.jump_cnt  = jumpCnt;
    assign jif.jwait_cnt = jwaitCnt;
`else
    assign jif.jump_cnt  = 16'd0;
    assign jif.jwait_cnt = 16'd0;
`endif

endmodule
